// File: rtl/text_console_pkg.sv
// Shared definitions for the text console writer: screen geometry defaults,
// control-code bytes and the controller state encoding.
// Optional feature macro: TEXT_CONSOLE_AUTOCLR_EN (adds the CLR_ROW state).
package text_console_pkg;

  localparam int DEF_COLS  = 80;
  localparam int DEF_ROWS  = 30;
  localparam int DEF_CELLS = DEF_COLS * DEF_ROWS;
  localparam logic [15:0] DEF_CLR_WORD = 16'h0720;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE
`ifdef TEXT_CONSOLE_AUTOCLR_EN
    , CLR_ROW
`endif
  } state_e;

endpackage

// File: rtl/text_console_writer_if.sv
// Character stream into the console writer: byte + attribute with a
// valid/ready handshake. The source drives char/attr/valid, the sink ready.
interface text_console_writer_if;
  import text_console_pkg::*;

  logic [7:0] char_i;
  logic [7:0] attr_i;
  logic       char_valid_i;
  logic       char_ready_o;

  modport master (
    output char_i, attr_i, char_valid_i,
    input  char_ready_o
  );

  modport slave (
    input  char_i, attr_i, char_valid_i,
    output char_ready_o
  );

endinterface

// File: rtl/text_console_writer.sv
// Text console writer: turns a handshaked character stream into {attr, ascii}
// cell writes for the Mode 0 framebuffer, tracks a hardware cursor, handles
// BS/LF/FF/CR and sequences full-screen clears one cell per cycle.
// Optional feature macro: TEXT_CONSOLE_AUTOCLR_EN -- clear each newly entered
// row (via the CLR_ROW state) before accepting further characters.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int          COLS     = DEF_COLS,
  parameter int          ROWS     = DEF_ROWS,
  parameter logic [15:0] CLR_WORD = DEF_CLR_WORD
) (
  input  logic                        clk,
  input  logic                        rst,
  text_console_writer_if.slave        char_if,
  input  logic                        clear_i,
  output logic                        we_o,
  output logic [15:0]                 vga_char_o,
  output logic [11:0]                 vga_char_waddr_o,
  output logic [6:0]                  cursor_x_o,
  output logic [4:0]                  cursor_y_o,
  output logic                        busy_o
);

  localparam int         CELLS  = COLS * ROWS;
  localparam logic [6:0] X_LAST = 7'(COLS - 1);
  localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [6:0]  cx_q, cx_d;
  logic [4:0]  cy_q, cy_d;
  logic        we_q, we_d;
  logic [15:0] data_q, data_d;
  logic [11:0] addr_q, addr_d;

  logic [11:0] cur_addr;
  logic [4:0]  y_inc;
`ifdef TEXT_CONSOLE_AUTOCLR_EN
  logic        new_row;
`endif

  // row*COLS+col; for COLS=80 this reduces to (y<<6)+(y<<4)+x.
  assign cur_addr = 12'(cy_q) * 12'(COLS) + 12'(cx_q);
  assign y_inc    = (cy_q == Y_LAST) ? 5'd0 : cy_q + 5'd1;

  assign char_if.char_ready_o = (state_q == IDLE) && !clear_i;
  assign busy_o               = (state_q != IDLE);

  assign we_o             = we_q;
  assign vga_char_o       = data_q;
  assign vga_char_waddr_o = addr_q;
  assign cursor_x_o       = cx_q;
  assign cursor_y_o       = cy_q;

  // State, cursor, clear counter and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR_ALL;
      cnt_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      we_q    <= we_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  // Next state: clear sequencing, character decode and cursor movement.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    we_d    = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;
`ifdef TEXT_CONSOLE_AUTOCLR_EN
    new_row = 1'b0;
`endif
    case (state_q)
      CLR_ALL: begin
        we_d   = 1'b1;
        data_d = CLR_WORD;
        addr_d = cnt_q;
        cnt_d  = cnt_q + 12'd1;
        if (cnt_q == 12'(CELLS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          cx_d    = '0;
          cy_d    = '0;
        end
      end
      IDLE: begin
        // A pending clear blocks the handshake, so it also wins over a char.
        if (clear_i) begin
          state_d = CLR_ALL;
          cnt_d   = '0;
        end else if (char_if.char_valid_i) begin
          case (char_if.char_i)
            CC_FF: begin
              state_d = CLR_ALL;
              cnt_d   = '0;
            end
            CC_CR: cx_d = '0;
            CC_LF: begin
              cx_d = '0;
              cy_d = y_inc;
`ifdef TEXT_CONSOLE_AUTOCLR_EN
              new_row = 1'b1;
`endif
            end
            CC_BS: begin
              // Cursor move only; the cell keeps its contents.
              if (cx_q != 7'd0) begin
                cx_d = cx_q - 7'd1;
              end else if (cy_q != 5'd0) begin
                cx_d = X_LAST;
                cy_d = cy_q - 5'd1;
              end
            end
            default: begin
              we_d   = 1'b1;
              data_d = {char_if.attr_i, char_if.char_i};
              addr_d = cur_addr;
              if (cx_q == X_LAST) begin
                cx_d = '0;
                cy_d = y_inc;
`ifdef TEXT_CONSOLE_AUTOCLR_EN
                new_row = 1'b1;
`endif
              end else begin
                cx_d = cx_q + 7'd1;
              end
            end
          endcase
        end
      end
`ifdef TEXT_CONSOLE_AUTOCLR_EN
      CLR_ROW: begin
        // Cursor sits at column 0 of the new row, so cur_addr is the row base.
        we_d   = 1'b1;
        data_d = CLR_WORD;
        addr_d = cur_addr + cnt_q;
        cnt_d  = cnt_q + 12'd1;
        if (cnt_q == 12'(COLS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = CLR_ALL;
        cnt_d   = '0;
      end
    endcase
`ifdef TEXT_CONSOLE_AUTOCLR_EN
    // Character write (if any) is already registered this edge; the row
    // clear starts on the following cycle.
    if (new_row) begin
      state_d = CLR_ROW;
      cnt_d   = '0;
    end
`endif
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: scoreboard of expected cell writes,
// a cursor model, and bounded waits on the clear sequences.
module tb_text_console_writer;
  import text_console_pkg::*;

`ifdef TEXT_CONSOLE_AUTOCLR_EN
  localparam bit AUTOCLR = 1'b1;
`else
  localparam bit AUTOCLR = 1'b0;
`endif

  typedef struct packed {
    logic [11:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic        we_o;
  logic [15:0] vga_char_o;
  logic [11:0] vga_char_waddr_o;
  logic [6:0]  cursor_x_o;
  logic [4:0]  cursor_y_o;
  logic        busy_o;

  text_console_writer_if cif();

  text_console_writer dut (
    .clk              (clk),
    .rst              (rst),
    .char_if          (cif),
    .clear_i          (clear_i),
    .we_o             (we_o),
    .vga_char_o       (vga_char_o),
    .vga_char_waddr_o (vga_char_waddr_o),
    .cursor_x_o       (cursor_x_o),
    .cursor_y_o       (cursor_y_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  wr_t sb[$];
  int  mx = 0;
  int  my = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clr(input int base, input int n);
    for (int k = 0; k < n; k++) sb.push_back({12'(base + k), DEF_CLR_WORD});
  endtask

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (we_o === 1'b1) begin
      wr_t e;
      chk("unexpected_write", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("write_addr_data", {4'h0, vga_char_waddr_o, vga_char_o}, {4'h0, e.a, e.d});
      end
    end
  end

  task automatic chk_cursor(input string tag);
    chk(tag, {cursor_y_o, cursor_x_o}, {5'(my), 7'(mx)});
  endtask

  task automatic wait_ready(input int exp_cyc, input string tag);
    int n = 0;
    while (cif.char_ready_o !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    cif.char_valid_i = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
    @(negedge clk);
    #1;
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    bit nr = 1'b0;
    bit ff = 1'b0;
    chk("ready_before_send", 32'(cif.char_ready_o), 32'd1);
    case (c)
      CC_BS: begin
        if (mx > 0) mx--;
        else if (my > 0) begin mx = DEF_COLS - 1; my--; end
      end
      CC_CR: mx = 0;
      CC_LF: begin
        mx = 0;
        my = (my == DEF_ROWS - 1) ? 0 : my + 1;
        nr = 1'b1;
      end
      CC_FF: begin
        push_clr(0, DEF_CELLS);
        ff = 1'b1;
      end
      default: begin
        sb.push_back({12'(my * DEF_COLS + mx), a, c});
        if (mx == DEF_COLS - 1) begin
          mx = 0;
          my = (my == DEF_ROWS - 1) ? 0 : my + 1;
          nr = 1'b1;
        end else begin
          mx++;
        end
      end
    endcase
    cif.char_i = c;
    cif.attr_i = a;
    cif.char_valid_i = 1'b1;
    tick();
    cif.char_valid_i = 1'b0;
    if (ff) begin
      wait_ready(DEF_CELLS, "ff_clear");
      mx = 0;
      my = 0;
      chk_cursor("cursor_after_ff");
    end else begin
      chk_cursor("cursor_after_send");
      if (nr && AUTOCLR) begin
        push_clr(my * DEF_COLS, DEF_COLS);
        wait_ready(DEF_COLS, "row_clear");
      end else begin
        @(negedge clk);
        #1;
        chk("send_drained", 32'(sb.size()), 32'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cif.char_i = 8'h5A;
    cif.attr_i = 8'h07;
    cif.char_valid_i = 1'b1;

    // Reset with valid held high: registered outputs clear, busy, not ready.
    tick();
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_data", 32'(vga_char_o), 32'd0);
    chk("rst_addr", 32'(vga_char_waddr_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd1);
    chk("rst_ready", 32'(cif.char_ready_o), 32'd0);
    chk_cursor("rst_cursor");
    push_clr(0, DEF_CELLS);
    rst = 1'b0;
    wait_ready(DEF_CELLS, "init_clear");
    chk_cursor("cursor_after_init");
    chk("idle_busy", 32'(busy_o), 32'd0);

    // First character at home.
    send(8'h41, 8'h1E);

    // Walk to (79,2), then write 'B' at the end of the row.
    send(CC_LF, 8'h00);
    send(CC_LF, 8'h00);
    for (int i = 0; i < DEF_COLS - 1; i++) send(8'h61 + 8'(i % 26), 8'h2F);
    send(8'h42, 8'h4C);

    // Down to row 29, then LF wraps back to the top row.
    while (my != DEF_ROWS - 1) send(CC_LF, 8'h00);
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 8'h07);
    send(CC_LF, 8'h00);

    // Backspace at home is a no-op; then at (0,4) it goes to (79,3).
    send(CC_BS, 8'h00);
    for (int i = 0; i < 4; i++) send(CC_LF, 8'h00);
    send(CC_BS, 8'h00);
    send(CC_BS, 8'h00);
    send(CC_CR, 8'h00);
    send(8'h7E, 8'h8F);

    // Form feed clears the screen and homes the cursor.
    send(CC_FF, 8'h00);

    // clear_i beats a simultaneous character; reset mid-clear restarts it.
    clear_i = 1'b1;
    cif.char_i = 8'h51;
    cif.attr_i = 8'h07;
    cif.char_valid_i = 1'b1;
    #1;
    chk("clear_blocks_ready", 32'(cif.char_ready_o), 32'd0);
    push_clr(0, 1000);
    tick();
    clear_i = 1'b0;
    cif.char_valid_i = 1'b0;
    chk("clear_busy", 32'(busy_o), 32'd1);
    repeat (1000) tick();
    rst = 1'b1;
    tick();
    chk("midrst_we", 32'(we_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd1);
    chk("midrst_writes_seen", 32'(sb.size()), 32'd0);
    mx = 0;
    my = 0;
    chk_cursor("midrst_cursor");
    push_clr(0, DEF_CELLS);
    rst = 1'b0;
    wait_ready(DEF_CELLS, "restart_clear");
    chk_cursor("cursor_after_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Upstream stage of the Mode 0 text framebuffer: converts a handshaked stream of byte-wide characters (CPU MMIO or UART) into 16-bit cell writes {attr, ascii} on the framebuffer write port (we, data, addr).
- Maintains a hardware cursor and interprets a small set of control codes.
- Performs full-screen and single-row clears by sequencing one cell write per cycle.

Parameters:
- COLS, 80, text columns per row.
- ROWS, 30, text rows.
- CLR_WORD, 16'h0720, cell value written when clearing (space, light-grey FG, black BG).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- char_i  in  8  character byte.
- attr_i  in  8  cell attribute {blink, bg[2:0], fg[3:0]}; sampled with char_i.
- char_valid_i  in  1  char_i/attr_i valid.
- char_ready_o  out  1  block can accept a character this cycle.
- clear_i  in  1  request full-screen clear (level; sampled in IDLE).
- we_o  out  1  framebuffer write enable.
- vga_char_o  out  16  cell data {attr, ascii}.
- vga_char_waddr_o  out  12  cell address, row*COLS+col, 0..2399.
- cursor_x_o  out  7  current column.
- cursor_y_o  out  5  current row.
- busy_o  out  1  a clear sequence is in progress.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: rst sampled high on a clk edge resets the block.
- States: CLR_ALL, IDLE, CLR_ROW.
- On reset:
  - state <= CLR_ALL, clear counter <= 0, cursor <= (0,0).
  - we_o=0, vga_char_o=0, vga_char_waddr_o=0, busy_o=1 in the first cycle after reset.
  - Reset asserted mid-sequence restarts CLR_ALL from address 0.
- Handshake:
  - char_ready_o = (state==IDLE) && !clear_i (combinational).
  - A transfer occurs on any edge with char_valid_i && char_ready_o.
- clear_i priority: if clear_i and char_valid_i are both high in IDLE, the clear wins and the character is not accepted.
- Write-port outputs (we_o, vga_char_o, vga_char_waddr_o) are all registered. We_o pulses for exactly one cycle per write.
- Printable (any byte except 0x08, 0x0A, 0x0C, 0x0D), accepted at edge N:
  - At N+1: we_o=1, vga_char_o={attr_i, char_i}, waddr = cursor at N.
  - Cursor advances at the same edge. At x=COLS-1 it wraps to x=0, y+1.
- 0x0D (CR): x <= 0. No write.
- 0x0A (LF): x <= 0, y <= y+1. No write.
- 0x08 (BS): moves the cursor only; it never erases.
  - x>0: x-1.
  - x=0 and y>0: (COLS-1, y-1).
  - (0,0): no change.
- 0x0C (FF): same effect as clear_i.
- Row wrap: when y would reach ROWS, y <= 0.
- CLR_ALL:
  - Writes CLR_WORD to addresses 0..ROWS*COLS-1, one per cycle: 2400 consecutive we_o pulses.
  - Then cursor <= (0,0) and state returns to IDLE.
  - busy_o=1 and char_ready_o=0 throughout.
- Address arithmetic: (y<<6)+(y<<4)+x, 12 bits, no overflow for the defaults.
- No scrolling: the framebuffer has no read port.

Optional Feature:
- Macro: TEXT_CONSOLE_AUTOCLR_EN.
- Defined:
  - Any cursor move into a new row (wrap, LF, or row wrap to 0) enters CLR_ROW.
  - CLR_ROW writes CLR_WORD to the COLS cells of the new row, one per cycle; busy_o=1 and ready=0 for those cycles. State then returns to IDLE.
  - If a character write is pending, its write precedes the row clear.
  - Does not apply to BS.
- Undefined: CLR_ROW state is absent; a new row retains its old contents.

Decomposition:
- text_console_pkg holds:
  - COLS/ROWS/CELLS defaults.
  - Control-code constants: CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D.
  - The state enum typedef.
- No sub-module is natural. Address computation is a single expression.

Test Plan:
- Reset, hold char_valid_i high -> exactly 2400 we_o pulses with data 16'h0720, addresses 0..2399 ascending; char_ready_o=0 until the cycle after the last write; cursor (0,0).
- From (0,0), send 'A' with attr 8'h1E -> next cycle we_o=1, data 16'h1E41, addr 0; cursor (1,0).
- Cursor (79,2), send 'B' -> write at addr 239; cursor (0,3). With TEXT_CONSOLE_AUTOCLR_EN: 80 clear writes at 240..319 follow, ready low 80 cycles.
- Cursor (5,29), send 0x0A -> no write, cursor (0,0). With the macro: clear of addresses 0..79.
- Send 0x08 at (0,4) -> cursor (79,3), no write. At (0,0) -> cursor unchanged.
- clear_i and char_valid_i high together in IDLE -> char not accepted; CLR_ALL runs. Assert rst at clear write 1000 -> sequence restarts at addr 0.
